// File: rtl/dift_tag_check_unit.sv
// DIFT tag check stage: checks operand/PC tags of each issued instruction against TCCR,
// records the highest-priority violation, counts it and optionally halts issue via an exception handshake.
package dift_pkg;
  localparam int DIFT_TAG_SIZE = 4;

  typedef enum logic [2:0] {
    DIFT_PROP_OPCLASS_ALU  = 3'd0,
    DIFT_PROP_OPCLASS_LOAD = 3'd1,
    DIFT_PROP_OPCLASS_STOR = 3'd2,
    DIFT_PROP_OPCLASS_BRAN = 3'd3,
    DIFT_PROP_OPCLASS_CSR  = 3'd4,
    DIFT_PROP_OPCLASS_OTH  = 3'd5
  } dift_prop_opclass_t;

  typedef enum logic [2:0] {
    CAUSE_NONE      = 3'd0,
    CAUSE_EXEC      = 3'd1,
    CAUSE_JALR      = 3'd2,
    CAUSE_BRAN      = 3'd3,
    CAUSE_LOAD_ADDR = 3'd4,
    CAUSE_STOR_ADDR = 3'd5,
    CAUSE_STOR_DATA = 3'd6
  } dift_cause_t;

  typedef struct packed {
    logic [2:0]  cause;
    logic [31:0] pc;
  } viol_rec_t;
endpackage

module dift_tag_check_unit
  import dift_pkg::*;
#(
  parameter int TAG_SIZE  = DIFT_TAG_SIZE,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           tccr_i,
  input  logic                 valid_i,
  input  logic                 ex_ready_i,
  input  dift_prop_opclass_t   opclass_i,
  input  logic                 is_jalr_i,
  input  logic                 is_jump_i,
  input  logic [TAG_SIZE-1:0]  operand_a_tag_i,
  input  logic [TAG_SIZE-1:0]  operand_b_tag_i,
  input  logic [TAG_SIZE-1:0]  pc_tag_i,
  input  logic [31:0]          pc_i,
  input  logic                 exc_ack_i,
  input  logic                 clear_cnt_i,
  output logic                 stall_o,
  output logic                 exc_req_o,
  output logic [2:0]           exc_cause_o,
  output logic [31:0]          exc_pc_o,
  output logic [CNT_WIDTH-1:0] viol_cnt_o
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state;
  viol_rec_t   rec;
  dift_cause_t cause;
  logic        a_set, b_set, pc_set, checked, viol, halt_en;
  logic [6:1]  fire;
  logic        unused_tccr;

  assign unused_tccr = tccr_i[7];
  assign halt_en     = tccr_i[6];
  assign a_set       = |operand_a_tag_i;
  assign b_set       = |operand_b_tag_i;
  assign pc_set      = |pc_tag_i;
  assign checked     = valid_i & ex_ready_i & (state == IDLE);

  assign fire[1] = tccr_i[5] & pc_set;
  assign fire[2] = tccr_i[0] & is_jalr_i & a_set;
  assign fire[3] = tccr_i[1] & (opclass_i == DIFT_PROP_OPCLASS_BRAN) & ~is_jump_i & (a_set | b_set);
  assign fire[4] = tccr_i[2] & (opclass_i == DIFT_PROP_OPCLASS_LOAD) & a_set;
  assign fire[5] = tccr_i[3] & (opclass_i == DIFT_PROP_OPCLASS_STOR) & a_set;
  assign fire[6] = tccr_i[4] & (opclass_i == DIFT_PROP_OPCLASS_STOR) & b_set;

  // Lowest cause number wins.
  always_comb begin
    cause = CAUSE_NONE;
    if      (fire[1]) cause = CAUSE_EXEC;
    else if (fire[2]) cause = CAUSE_JALR;
    else if (fire[3]) cause = CAUSE_BRAN;
    else if (fire[4]) cause = CAUSE_LOAD_ADDR;
    else if (fire[5]) cause = CAUSE_STOR_ADDR;
    else if (fire[6]) cause = CAUSE_STOR_DATA;
  end

  assign viol = checked & (cause != CAUSE_NONE);

  // Detect term is combinational so the following instruction is held off in the same cycle.
  assign stall_o     = (state == REQ) | (viol & halt_en);
  assign exc_cause_o = rec.cause;
  assign exc_pc_o    = rec.pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      exc_req_o  <= 1'b0;
      rec        <= '0;
      viol_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: if (viol && halt_en) begin
          state     <= REQ;
          exc_req_o <= 1'b1;
        end
        REQ: if (exc_ack_i) begin
          state     <= IDLE;
          exc_req_o <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          exc_req_o <= 1'b0;
        end
      endcase

      if (viol) rec <= '{cause: cause, pc: pc_i};

      if (clear_cnt_i)                  viol_cnt_o <= '0;
      else if (viol && !(&viol_cnt_o))  viol_cnt_o <= viol_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_dift_tag_check_unit.sv
// Directed bench for dift_tag_check_unit; a second instance with a 2-bit counter covers saturation.
module tb_dift_tag_check_unit;
  import dift_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [7:0]         tccr;
  logic               valid, ex_ready, is_jalr, is_jump, exc_ack, clear_cnt;
  dift_prop_opclass_t opclass;
  logic [3:0]         a_tag, b_tag, pc_tag;
  logic [31:0]        pc;

  logic        stall, req, s_stall, s_req;
  logic [2:0]  cause, s_cause;
  logic [31:0] epc, s_epc;
  logic [15:0] cnt;
  logic [1:0]  s_cnt;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  dift_tag_check_unit #(.TAG_SIZE(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .tccr_i(tccr), .valid_i(valid), .ex_ready_i(ex_ready),
    .opclass_i(opclass), .is_jalr_i(is_jalr), .is_jump_i(is_jump),
    .operand_a_tag_i(a_tag), .operand_b_tag_i(b_tag), .pc_tag_i(pc_tag), .pc_i(pc),
    .exc_ack_i(exc_ack), .clear_cnt_i(clear_cnt), .stall_o(stall), .exc_req_o(req),
    .exc_cause_o(cause), .exc_pc_o(epc), .viol_cnt_o(cnt)
  );

  dift_tag_check_unit #(.TAG_SIZE(4), .CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .tccr_i(tccr), .valid_i(valid), .ex_ready_i(ex_ready),
    .opclass_i(opclass), .is_jalr_i(is_jalr), .is_jump_i(is_jump),
    .operand_a_tag_i(a_tag), .operand_b_tag_i(b_tag), .pc_tag_i(pc_tag), .pc_i(pc),
    .exc_ack_i(exc_ack), .clear_cnt_i(clear_cnt), .stall_o(s_stall), .exc_req_o(s_req),
    .exc_cause_o(s_cause), .exc_pc_o(s_epc), .viol_cnt_o(s_cnt)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_in;
    valid = 0; ex_ready = 1; opclass = DIFT_PROP_OPCLASS_ALU; is_jalr = 0; is_jump = 0;
    a_tag = 0; b_tag = 0; pc_tag = 0; pc = 0;
  endtask

  task automatic drive(input dift_prop_opclass_t oc, input logic jr, input logic jp,
                       input logic [3:0] a, input logic [3:0] b, input logic [3:0] pt,
                       input logic [31:0] p);
    valid = 1; ex_ready = 1; opclass = oc; is_jalr = jr; is_jump = jp;
    a_tag = a; b_tag = b; pc_tag = pt; pc = p;
  endtask

  task automatic test_reset;
    rst = 1; tccr = 0; exc_ack = 0; clear_cnt = 0; idle_in();
    tick(); tick(); rst = 0; #1;
    vec++; if (req !== 0 || stall !== 0) begin err++; $display("FAIL reset_req_stall: got req=%0b stall=%0b want 0/0", req, stall); end
    vec++; if (cause !== 0 || epc !== 0 || cnt !== 0) begin err++; $display("FAIL reset_regs: got cause=%0d pc=%h cnt=%0d want 0", cause, epc, cnt); end
  endtask

  task automatic test_load_halt;
    tccr = 8'h44;
    tick(); drive(DIFT_PROP_OPCLASS_LOAD, 0, 0, 4'h2, 0, 0, 32'h100); #1;
    vec++; if (stall !== 1) begin err++; $display("FAIL load_stall_n: got %0b want 1", stall); end
    tick(); idle_in();
    vec++; if (req !== 1) begin err++; $display("FAIL load_req_n1: got %0b want 1", req); end
    vec++; if (cause !== 3'd4 || epc !== 32'h100 || cnt !== 16'd1) begin err++; $display("FAIL load_capture: got cause=%0d pc=%h cnt=%0d want 4/100/1", cause, epc, cnt); end
    vec++; if (stall !== 1) begin err++; $display("FAIL load_stall_req: got %0b want 1", stall); end
    tick();
    tick(); exc_ack = 1;
    tick(); exc_ack = 0;
    vec++; if (req !== 0 || stall !== 0) begin err++; $display("FAIL load_ack: got req=%0b stall=%0b want 0/0", req, stall); end
  endtask

  task automatic test_stor_priority;
    tccr = 8'h18;
    tick(); drive(DIFT_PROP_OPCLASS_STOR, 0, 0, 4'h1, 4'h8, 0, 32'h300); #1;
    vec++; if (stall !== 0) begin err++; $display("FAIL stor_nostall: got %0b want 0", stall); end
    tick(); idle_in();
    vec++; if (cause !== 3'd5 || epc !== 32'h300) begin err++; $display("FAIL stor_addr_cause: got %0d pc=%h want 5/300", cause, epc); end
    tccr = 8'h10; drive(DIFT_PROP_OPCLASS_STOR, 0, 0, 4'h1, 4'h8, 0, 32'h304);
    tick(); idle_in();
    vec++; if (cause !== 3'd6) begin err++; $display("FAIL stor_data_cause: got %0d want 6", cause); end
    tccr = 8'h38; drive(DIFT_PROP_OPCLASS_STOR, 0, 0, 4'h1, 4'h8, 4'h4, 32'h308);
    tick(); idle_in();
    vec++; if (cause !== 3'd1 || epc !== 32'h308) begin err++; $display("FAIL exec_cause: got %0d pc=%h want 1/308", cause, epc); end
    vec++; if (cnt !== 16'd4 || req !== 0) begin err++; $display("FAIL stor_cnt: got cnt=%0d req=%0b want 4/0", cnt, req); end
  endtask

  task automatic test_jalr_count;
    tccr = 8'h01; clear_cnt = 1;
    tick(); clear_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive(DIFT_PROP_OPCLASS_BRAN, 1, 1, 4'h1, 0, 0, 32'h200 + 4 * i); #1;
      vec++; if (stall !== 0) begin err++; $display("FAIL jalr_stall%0d: got %0b want 0", i, stall); end
      tick();
    end
    idle_in();
    vec++; if (req !== 0 || cnt !== 16'd3 || s_cnt !== 2'd3) begin err++; $display("FAIL jalr_cnt: got req=%0b cnt=%0d scnt=%0d want 0/3/3", req, cnt, s_cnt); end
    vec++; if (cause !== 3'd2 || epc !== 32'h208) begin err++; $display("FAIL jalr_capture: got cause=%0d pc=%h want 2/208", cause, epc); end
  endtask

  task automatic test_saturate;
    tccr = 8'h04; clear_cnt = 1;
    tick(); clear_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(DIFT_PROP_OPCLASS_LOAD, 0, 0, 4'h8, 0, 0, 32'h400 + 4 * i);
      tick();
    end
    idle_in();
    vec++; if (s_cnt !== 2'd3 || cnt !== 16'd5) begin err++; $display("FAIL sat_cnt: got scnt=%0d cnt=%0d want 3/5", s_cnt, cnt); end
    drive(DIFT_PROP_OPCLASS_LOAD, 0, 0, 4'h8, 0, 0, 32'h500); clear_cnt = 1;
    tick(); clear_cnt = 0; idle_in();
    vec++; if (s_cnt !== 0 || cnt !== 0) begin err++; $display("FAIL clear_prio: got scnt=%0d cnt=%0d want 0/0", s_cnt, cnt); end
    vec++; if (cause !== 3'd4 || epc !== 32'h500) begin err++; $display("FAIL clear_capture: got cause=%0d pc=%h want 4/500", cause, epc); end
  endtask

  task automatic test_reset_in_req;
    tccr = 8'h44;
    drive(DIFT_PROP_OPCLASS_LOAD, 0, 0, 4'h1, 0, 0, 32'h600);
    tick(); idle_in();
    vec++; if (req !== 1 || cnt !== 16'd1) begin err++; $display("FAIL rreq_enter: got req=%0b cnt=%0d want 1/1", req, cnt); end
    rst = 1;
    tick(); rst = 0; #1;
    vec++; if (req !== 0 || stall !== 0 || cnt !== 0) begin err++; $display("FAIL rreq_reset: got req=%0b stall=%0b cnt=%0d want 0/0/0", req, stall, cnt); end
    drive(DIFT_PROP_OPCLASS_LOAD, 0, 0, 4'h1, 0, 4'h1, 32'h700); ex_ready = 0; #1;
    vec++; if (stall !== 0) begin err++; $display("FAIL notready_stall: got %0b want 0", stall); end
    tick(); idle_in();
    vec++; if (cnt !== 0 || cause !== 0 || req !== 0) begin err++; $display("FAIL notready_regs: got cnt=%0d cause=%0d req=%0b want 0/0/0", cnt, cause, req); end
  endtask

  task automatic test_bran_jump;
    tccr = 8'h02;
    drive(DIFT_PROP_OPCLASS_BRAN, 0, 0, 0, 4'h2, 0, 32'h800);
    tick(); idle_in();
    vec++; if (cause !== 3'd3 || cnt !== 16'd1 || epc !== 32'h800) begin err++; $display("FAIL bran_cause: got cause=%0d cnt=%0d pc=%h want 3/1/800", cause, cnt, epc); end
    tccr = 8'h42;
    drive(DIFT_PROP_OPCLASS_BRAN, 0, 1, 4'h1, 0, 0, 32'h804); #1;
    vec++; if (stall !== 0) begin err++; $display("FAIL jal_stall: got %0b want 0", stall); end
    tick(); idle_in();
    vec++; if (cnt !== 16'd1 || req !== 0 || epc !== 32'h800) begin err++; $display("FAIL jal_noviol: got cnt=%0d req=%0b pc=%h want 1/0/800", cnt, req, epc); end
    exc_ack = 1;
    tick(); exc_ack = 0;
    tick();
    vec++; if (req !== 0 || stall !== 0 || cnt !== 16'd1) begin err++; $display("FAIL ack_idle: got req=%0b stall=%0b cnt=%0d want 0/0/1", req, stall, cnt); end
  endtask

  task automatic test_back_to_back;
    tccr = 8'h7f;
    for (int i = 0; i < 4; i++) begin
      drive(i[0] ? DIFT_PROP_OPCLASS_STOR : DIFT_PROP_OPCLASS_LOAD, 0, 0, 0, 0, 0, 32'h900 + 4 * i); #1;
      vec++; if (stall !== 0) begin err++; $display("FAIL b2b_stall%0d: got %0b want 0", i, stall); end
      tick();
    end
    idle_in();
    vec++; if (cnt !== 16'd1 || req !== 0) begin err++; $display("FAIL b2b_cnt: got cnt=%0d req=%0b want 1/0", cnt, req); end
  endtask

  initial begin
    test_reset();
    test_load_halt();
    test_stor_priority();
    test_jalr_count();
    test_saturate();
    test_reset_in_req();
    test_bran_jump();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/dift_tag_check_unit.md
# dift_tag_check_unit

Tag check stage of the DIFT extension, placed in EX directly beside the tag propagation unit. It checks the operand and PC tags of every issued instruction against the tag check configuration register (TCCR). On a policy violation it captures the cause and PC and counts the event. If halting is enabled, it stalls issue and runs a request/acknowledge handshake with the controller, which raises the DIFT exception.

## Interface
Parameters:
- TAG_SIZE, default DIFT_TAG_SIZE: width of every tag input.
- CNT_WIDTH, default 16: width of the violation counter.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- tccr_i  in  8  check configuration:
  - bit0 jalr_en, bit1 bran_en, bit2 load_addr_en, bit3 stor_addr_en, bit4 stor_data_en, bit5 exec_en.
  - bit6 halt_en: 1 = raise exception, 0 = count only.
  - bit7 reserved, ignored.
- valid_i  in  1  an instruction is present in EX.
- ex_ready_i  in  1  EX accepts the instruction this cycle. An instruction is checked only when valid_i & ex_ready_i.
- opclass_i  in  dift_prop_opclass_t  operation class, same encoding as propagation.
- is_jalr_i  in  1  the instruction is JALR (opclass BRAN).
- is_jump_i  in  1  the instruction is JAL/JALR, not a conditional branch.
- operand_a_tag_i  in  TAG_SIZE  rs1 tag.
- operand_b_tag_i  in  TAG_SIZE  rs2 tag.
- pc_tag_i  in  TAG_SIZE  tag of the fetched instruction word.
- pc_i  in  32  PC of the instruction in EX.
- exc_ack_i  in  1  controller has taken the exception.
- clear_cnt_i  in  1  synchronous clear of the violation counter.
- stall_o  out  1  blocks issue into EX.
- exc_req_o  out  1  exception request, registered.
- exc_cause_o  out  3  cause of the last captured violation.
- exc_pc_o  out  32  PC of the last captured violation.
- viol_cnt_o  out  CNT_WIDTH  violation count, saturating.

## Operation
- A tag is "set" when its OR-reduction is 1.
- Checks are evaluated only on a checked instruction (valid_i & ex_ready_i) while state is IDLE.
- Check per cause; each cause fires only if its enable bit is set:
  - exec: pc_tag set (exec_en).
  - jalr: is_jalr_i & a set (jalr_en).
  - bran: opclass BRAN & !is_jump_i & (a set | b set) (bran_en).
  - load_addr: opclass LOAD & a set (load_addr_en).
  - stor_addr: opclass STOR & a set (stor_addr_en).
  - stor_data: opclass STOR & b set (stor_data_en).
- Cause encoding: 0 none, 1 exec, 2 jalr, 3 bran, 4 load_addr, 5 stor_addr, 6 stor_data, 7 unused.
- Priority when several causes fire: 1 > 2 > 3 > 4 > 5 > 6. Only the highest-priority cause is recorded.
- On any violation:
  - exc_cause_o and exc_pc_o load the cause and pc_i.
  - viol_cnt_o increments, saturating at all-ones.
  - These updates happen regardless of halt_en.
- FSM:
  - IDLE: a violation with halt_en=1 moves to REQ. Without one, stay.
  - REQ: exc_req_o=1. exc_ack_i=1 moves to IDLE. No checks are evaluated in REQ; capture registers and counter hold.
- stall_o = (state==REQ) | (a violation is detected this cycle & halt_en). The detect term is combinational so the next instruction is not issued.
- clear_cnt_i has priority over an increment in the same cycle: the counter becomes 0.
- exc_ack_i is ignored in IDLE.
- tccr_i changes take effect on the next checked instruction. Clearing halt_en while in REQ does not abort the request.

## Timing
- Reset values: state IDLE; exc_req_o 0, stall_o 0, exc_cause_o 0, exc_pc_o 0, viol_cnt_o 0.
- rst in REQ returns to IDLE next edge, with no ack required.
- Violation checked in cycle N:
  - stall_o is 1 in N.
  - exc_req_o, exc_cause_o, exc_pc_o and viol_cnt_o are updated at N+1.
- exc_ack_i in cycle M (M≥N+1): exc_req_o and stall_o are 0 from M+1, and checking resumes in M+1.
- Back-to-back checked instructions with no violation: zero stall cycles.
- Count-only violation: no stall; exc_cause_o, exc_pc_o and viol_cnt_o update at N+1.

## Test plan
- Reset, then a LOAD with a tagged, load_addr_en=1, halt_en=1, pc 0x100 → stall_o=1 in N. At N+1: exc_req_o=1, cause 4, exc_pc_o 0x100, count 1. Ack at N+3 → exc_req_o=0 at N+4.
- STOR with a and b both tagged, stor_addr_en and stor_data_en set → cause 5. With only stor_data_en set → cause 6. With pc_tag also tagged and exec_en set → cause 1.
- halt_en=0, three consecutive tagged JALR with jalr_en=1 → stall_o stays 0, exc_req_o stays 0, count 3, cause 2, exc_pc_o = PC of the third.
- CNT_WIDTH=2: five violations in count-only mode → count 3 (saturated). clear_cnt_i asserted together with a violation → count 0.
- rst asserted in REQ before ack → next cycle exc_req_o=0, stall_o=0, count 0. A tagged instruction issued with valid_i=1, ex_ready_i=0 → no detection.
- Conditional branch with b tagged, bran_en=1 → cause 3. JAL with is_jump_i=1 and a tagged, jalr_en=0 → no violation. exc_ack_i pulsed in IDLE → no effect.
